// File: rtl/aes_ti_pkg.sv
// Shared types and constants for the threshold-implementation AES S-box sequencer.
// Optional fresh-mask handshake is enabled with the AES_TI_REMASK_EN macro.
package aes_ti_pkg;

    localparam int STAGES_DEF    = 4;
    localparam int NUM_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sbox_state_e;

    // Counter width; never below 1 so a single-byte request still has a select bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((32'sd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/ti_valid_pipe.sv
// Valid shift register mirroring the S-box pipeline: vld_o[k] is the load enable
// of register k, out_o is the registered enable of the last stage.
module ti_valid_pipe #(
    parameter int STAGES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    output logic [STAGES-1:0] vld_o,
    output logic              out_o
);

    logic [STAGES-1:0] vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= STAGES'({vld_q, vld_i});
        end
    end

    // Stage 0 loads in the issue cycle itself; stage k one cycle after stage k-1.
    assign vld_o = STAGES'({vld_q, vld_i});
    assign out_o = vld_q[STAGES-1];

endmodule

// File: rtl/ti_sbox_sequencer.sv
// Control sequencer for the pipelined TI AES S-box: issues bytes, drives stage
// enables and result-slot captures. AES_TI_REMASK_EN adds the fresh-mask handshake.
module ti_sbox_sequencer import aes_ti_pkg::*; #(
    parameter  int STAGES    = STAGES_DEF,
    parameter  int NUM_BYTES = NUM_BYTES_DEF,
    localparam int SelW      = clog2_min1(NUM_BYTES)
) (
    input  logic              ClkxCI,
    input  logic              RstxRI,
    input  logic              StartxSI,
    output logic              BusyxSO,
    output logic              IssuexSO,
    output logic [SelW-1:0]   ByteSelxDO,
    output logic [STAGES-1:0] EnxSO,
    output logic              CapturexSO,
    output logic [SelW-1:0]   CapSelxDO,
    output logic              DonexSO,
`ifdef AES_TI_REMASK_EN
    output logic              RndReqxSO,
    input  logic              RndVldxSI,
`endif
    output sbox_state_e       DbgStatexDO
);

    localparam logic [SelW-1:0] LastIdx = SelW'(NUM_BYTES - 1);

    sbox_state_e       state_q;
    logic [SelW-1:0]   issue_cnt_q;
    logic [SelW-1:0]   cap_cnt_q;
    logic [STAGES-1:0] vld;
    logic              issue;
    logic              pipe_out;
    logic              capture;
    logic              last_issue;
    logic              done;

    // Handshakes: StartxSI is taken only in a cycle with BusyxSO=0 and is never queued;
    // with remasking, a byte issues only in a cycle where RndReqxSO and RndVldxSI are both 1.
`ifdef AES_TI_REMASK_EN
    logic cap_dly_q;

    assign issue = (state_q == ISSUE) && RndVldxSI;

    // Mask refresh adds one register between the last stage and the result slot.
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            cap_dly_q <= 1'b0;
        end else begin
            cap_dly_q <= pipe_out;
        end
    end

    assign capture   = cap_dly_q;
    assign RndReqxSO = (state_q == ISSUE);
`else
    assign issue   = (state_q == ISSUE);
    assign capture = pipe_out;
`endif

    ti_valid_pipe #(
        .STAGES (STAGES)
    ) u_valid_pipe (
        .clk_i (ClkxCI),
        .rst_i (RstxRI),
        .vld_i (issue),
        .vld_o (vld),
        .out_o (pipe_out)
    );

    assign last_issue = issue && (issue_cnt_q == LastIdx);
    assign done       = capture && (cap_cnt_q == LastIdx);

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE:    if (StartxSI)   state_q <= ISSUE;
                ISSUE:   if (last_issue) state_q <= DRAIN;
                DRAIN:   if (done)       state_q <= IDLE;
                default:                 state_q <= IDLE;
            endcase

            if (issue && (issue_cnt_q != LastIdx)) issue_cnt_q <= issue_cnt_q + SelW'(1);
            if (capture && (cap_cnt_q != LastIdx)) cap_cnt_q <= cap_cnt_q + SelW'(1);

            if ((state_q == DRAIN) && done) begin
                issue_cnt_q <= '0;
                cap_cnt_q   <= '0;
            end
        end
    end

    assign BusyxSO     = (state_q != IDLE);
    assign IssuexSO    = issue;
    assign ByteSelxDO  = issue_cnt_q;
    assign EnxSO       = vld;
    assign CapturexSO  = capture;
    assign CapSelxDO   = cap_cnt_q;
    assign DonexSO     = done;
    assign DbgStatexDO = state_q;

endmodule

// File: tb/tb_ti_sbox_sequencer.sv
// Directed bench for ti_sbox_sequencer (4x4 instance plus a 1x1 instance).
// With AES_TI_REMASK_EN defined the fresh-mask pattern case is also exercised.
module tb_ti_sbox_sequencer;

    localparam int N0 = 4;
    localparam int S0 = 4;
    localparam int N1 = 1;
    localparam int S1 = 1;
`ifdef AES_TI_REMASK_EN
    localparam int REM = 1;
`else
    localparam int REM = 0;
`endif
    localparam int LAT0 = S0 + REM;
    localparam int LAT1 = S1 + REM;
    localparam int P0   = N0 + LAT0 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0;
    logic       start1;

    logic       busy0, issue0, cap0, done0;
    logic [1:0] sel0, capsel0, state0;
    logic [3:0] en0;
    logic       busy1, issue1, cap1, done1;
    logic [0:0] sel1, capsel1, en1;
    logic [1:0] state1;
`ifdef AES_TI_REMASK_EN
    logic       rnd_vld;
    logic       rndreq0, rndreq1;
    int         pat [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    int         iss_tab [4] = '{1, 4, 5, 7};
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    ti_sbox_sequencer #(.STAGES(S0), .NUM_BYTES(N0)) dut0 (
        .ClkxCI      (clk),
        .RstxRI      (rst),
        .StartxSI    (start0),
        .BusyxSO     (busy0),
        .IssuexSO    (issue0),
        .ByteSelxDO  (sel0),
        .EnxSO       (en0),
        .CapturexSO  (cap0),
        .CapSelxDO   (capsel0),
        .DonexSO     (done0),
`ifdef AES_TI_REMASK_EN
        .RndReqxSO   (rndreq0),
        .RndVldxSI   (rnd_vld),
`endif
        .DbgStatexDO (state0)
    );

    ti_sbox_sequencer #(.STAGES(S1), .NUM_BYTES(N1)) dut1 (
        .ClkxCI      (clk),
        .RstxRI      (rst),
        .StartxSI    (start1),
        .BusyxSO     (busy1),
        .IssuexSO    (issue1),
        .ByteSelxDO  (sel1),
        .EnxSO       (en1),
        .CapturexSO  (cap1),
        .CapSelxDO   (capsel1),
        .DonexSO     (done1),
`ifdef AES_TI_REMASK_EN
        .RndReqxSO   (rndreq1),
        .RndVldxSI   (rnd_vld),
`endif
        .DbgStatexDO (state1)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs for cycle c of an always-ready request (c=0: idle).
    task automatic check_cycle(input string tg, input int c, input int n, input int s, input int lat,
                               input logic [31:0] busy, input logic [31:0] issue, input logic [31:0] sel,
                               input logic [31:0] en, input logic [31:0] cap, input logic [31:0] capsel,
                               input logic [31:0] done, input logic [31:0] st);
        int exp_en;
        exp_en = 0;
        for (int k = 0; k < s; k++)
            if (c >= 1 + k && c <= n + k) exp_en = exp_en | (1 << k);
        check($sformatf("%s c%0d busy", tg, c), busy, (c >= 1 && c <= n + lat) ? 1 : 0);
        check($sformatf("%s c%0d issue", tg, c), issue, (c >= 1 && c <= n) ? 1 : 0);
        if (c >= 1 && c <= n) check($sformatf("%s c%0d bytesel", tg, c), sel, c - 1);
        check($sformatf("%s c%0d en", tg, c), en, exp_en);
        check($sformatf("%s c%0d capture", tg, c), cap, (c >= lat + 1 && c <= n + lat) ? 1 : 0);
        if (c >= lat + 1 && c <= n + lat) check($sformatf("%s c%0d capsel", tg, c), capsel, c - lat - 1);
        check($sformatf("%s c%0d done", tg, c), done, (c == n + lat) ? 1 : 0);
        check($sformatf("%s c%0d state", tg, c), st,
              (c == 0 || c > n + lat) ? 0 : (c <= n) ? 1 : 2);
    endtask

    task automatic chk0(input string tg, input int c);
        check_cycle(tg, c, N0, S0, LAT0, 32'(busy0), 32'(issue0), 32'(sel0), 32'(en0),
                    32'(cap0), 32'(capsel0), 32'(done0), 32'(state0));
`ifdef AES_TI_REMASK_EN
        check($sformatf("%s c%0d rndreq", tg, c), 32'(rndreq0), (c >= 1 && c <= N0) ? 1 : 0);
`endif
    endtask

    task automatic chk1(input string tg, input int c);
        check_cycle(tg, c, N1, S1, LAT1, 32'(busy1), 32'(issue1), 32'(sel1), 32'(en1),
                    32'(cap1), 32'(capsel1), 32'(done1), 32'(state1));
`ifdef AES_TI_REMASK_EN
        check($sformatf("%s c%0d rndreq", tg, c), 32'(rndreq1), (c >= 1 && c <= N1) ? 1 : 0);
`endif
    endtask

    // Scoreboard: each observed capture on dut0 must match the next expected capture cycle.
    task automatic sb_watch(input string tg, input int c);
        if (cap0) begin
            if (exp_q.size() == 0) check($sformatf("%s sb extra capture", tg), 32'(c), -1);
            else check($sformatf("%s sb capture cycle", tg), 32'(c), int'(exp_q.pop_front()));
        end
    endtask

`ifdef AES_TI_REMASK_EN
    function automatic int tab_idx(input int v);
        for (int i = 0; i < 4; i++) if (iss_tab[i] == v) return i;
        return -1;
    endfunction
`endif

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
`ifdef AES_TI_REMASK_EN
        rnd_vld = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk0("reset", 0);
        chk1("reset1", 0);
        rst = 1'b0;
        @(negedge clk);
        chk0("idle", 0);

        // Single request
        start0 = 1'b1;
        for (int c = LAT0 + 1; c <= N0 + LAT0; c++) exp_q.push_back(32'(c));
        for (int c = 1; c <= P0; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            chk0("t1", c);
            sb_watch("t1", c);
        end
        check("t1 sb empty", 32'(exp_q.size()), 0);

        // Start held high: three back-to-back requests, period P0
        start0 = 1'b1;
        for (int t = 1; t <= 3 * P0; t++) begin
            @(negedge clk);
            chk0("t2", t % P0);
        end
        start0 = 1'b0;
        @(negedge clk);
        chk0("t2 tail", P0);

        // Reset in cycle 6 of a request
        start0 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            chk0("t3", c);
        end
        rst = 1'b1;
        @(negedge clk);
        chk0("t3 rst", 0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk0("t3 quiet", 0);
        end
        start0 = 1'b1;
        for (int c = 1; c <= P0; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            chk0("t3 restart", c);
        end

`ifdef AES_TI_REMASK_EN
        // Fresh-mask availability pattern 1,0,0,1,1,0,1
        rnd_vld = pat[1][0];
        start0  = 1'b1;
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd12);
        for (int c = 1; c <= 13; c++) begin
            int ii;
            int ci;
            int een;
            @(negedge clk);
            start0 = 1'b0;
            ii  = tab_idx(c);
            ci  = tab_idx(c - 5);
            een = 0;
            for (int k = 0; k < 4; k++) if (tab_idx(c - k) >= 0) een = een | (1 << k);
            check($sformatf("t5 c%0d issue", c), 32'(issue0), (ii >= 0) ? 1 : 0);
            if (ii >= 0) check($sformatf("t5 c%0d bytesel", c), 32'(sel0), ii);
            check($sformatf("t5 c%0d en", c), 32'(en0), een);
            check($sformatf("t5 c%0d capture", c), 32'(cap0), (ci >= 0) ? 1 : 0);
            if (ci >= 0) check($sformatf("t5 c%0d capsel", c), 32'(capsel0), ci);
            check($sformatf("t5 c%0d done", c), 32'(done0), (c == 12) ? 1 : 0);
            check($sformatf("t5 c%0d busy", c), 32'(busy0), (c <= 12) ? 1 : 0);
            check($sformatf("t5 c%0d rndreq", c), 32'(rndreq0), (c <= 7) ? 1 : 0);
            check($sformatf("t5 c%0d state", c), 32'(state0), (c <= 7) ? 1 : (c <= 12) ? 2 : 0);
            sb_watch("t5", c);
            rnd_vld = (c + 1 <= 7) ? pat[c + 1][0] : 1'b1;
        end
        check("t5 sb empty", 32'(exp_q.size()), 0);
`endif

        // Minimal configuration: one byte, one stage
        start1 = 1'b1;
        for (int c = 1; c <= N1 + LAT1 + 1; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk1("t6", c);
        end
        chk0("t6 dut0 idle", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
